// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_ctrl
// Brief    : Valid/ready sequencer for a clock-enabled pipelined FFT core;
//            drives core reset/enable, drains with zeros on flush, frames results.
// Option   : FFT_FRAME_CTRL_STATS_EN enables the o_latency / o_frames counters.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_ctrl #(
    parameter int IWIDTH = 12,
    parameter int OWIDTH = 19,
    parameter int LGN    = 12,
    parameter int PW     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [2*IWIDTH-1:0]   s_sample,
    output logic                  o_fft_reset,
    output logic                  o_fft_ce,
    output logic [2*IWIDTH-1:0]   o_fft_sample,
    input  logic [2*OWIDTH-1:0]   i_fft_result,
    input  logic                  i_fft_sync,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*OWIDTH-1:0]   m_data,
    output logic [LGN-1:0]        m_bin,
    output logic                  m_first,
    output logic                  m_last,
    output logic                  o_busy,
    output logic                  o_err_sync,
    output logic [31:0]           o_latency,
    output logic [31:0]           o_frames
);

    localparam logic [1:0]     c_idle  = 2'd0;
    localparam logic [1:0]     c_clr   = 2'd1;
    localparam logic [1:0]     c_run   = 2'd2;
    localparam logic [1:0]     c_flush = 2'd3;
    localparam logic [LGN-1:0] c_n_last = {LGN{1'b1}};

    logic [1:0]     r_state, w_next_state;
    logic [LGN-1:0] r_in_idx;
    logic [PW-1:0]  r_pending;
    logic           r_out_active, r_fresh, r_flush_req;
    logic [LGN-1:0] r_bin;

    logic w_run, w_flush, w_out_active, w_out_ok, w_ce, w_accept, w_hs;
    logic w_last_hs, w_wrap, w_err, w_flush_go;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= c_idle;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_run        = (r_state == c_run);
        w_flush      = (r_state == c_flush);
        // sync arriving with a fresh result opens the output stream in that same cycle
        w_out_active = (w_run | w_flush) & (r_out_active | (r_fresh & i_fft_sync));
        m_valid      = !i_reset & w_out_active & r_fresh;
        w_out_ok     = !m_valid | m_ready;
        w_hs         = m_valid & m_ready;
        w_last_hs    = w_hs & (r_bin == c_n_last);
        // stop feeding zeros the moment the last owed frame completes
        w_flush_go   = (r_pending > PW'(1)) | ((r_pending == PW'(1)) & !w_last_hs);
        w_ce         = !i_reset & w_out_ok & ((w_run & s_valid) | (w_flush & w_flush_go));
        s_ready      = !i_reset & w_run & w_out_ok;
        w_accept     = s_valid & s_ready;
        w_wrap       = w_accept & (r_in_idx == c_n_last);
        w_err        = !i_reset & r_out_active & r_fresh & i_fft_sync & (r_bin != '0);
        case (r_state)
            c_idle:  if (s_valid) w_next_state = c_clr;
            c_clr:   w_next_state = c_run;
            c_run:   if (r_flush_req && (r_in_idx == '0)) w_next_state = c_flush;
            default: if ((r_pending == '0) && !r_fresh) w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_in_idx     <= '0;
            r_pending    <= '0;
            r_out_active <= 1'b0;
            r_fresh      <= 1'b0;
            r_bin        <= '0;
            r_flush_req  <= 1'b0;
        end else begin
            if (w_ce)      r_fresh <= 1'b1;
            else if (w_hs) r_fresh <= 1'b0;

            if ((r_state == c_idle) || (r_state == c_clr)) begin
                r_out_active <= 1'b0;
                r_bin        <= '0;
            end else begin
                r_out_active <= w_out_active;
                if (w_err)     r_bin <= '0;
                else if (w_hs) r_bin <= r_bin + LGN'(1);
            end

            if (w_accept) r_in_idx <= r_in_idx + LGN'(1);

            if (w_wrap && !w_last_hs)      r_pending <= r_pending + PW'(1);
            else if (!w_wrap && w_last_hs) r_pending <= r_pending - PW'(1);

            if (w_run && (w_next_state == c_flush)) r_flush_req <= 1'b0;
            else if (w_run && i_flush)              r_flush_req <= 1'b1;
        end
    end

    assign o_fft_reset  = i_reset | (r_state == c_clr);
    assign o_fft_ce     = w_ce;
    assign o_fft_sample = w_run ? s_sample : '0;
    assign m_data       = i_fft_result;
    assign m_bin        = r_bin;
    assign m_first      = m_valid & (r_bin == '0);
    assign m_last       = m_valid & (r_bin == c_n_last);
    assign o_busy       = !i_reset & (r_state != c_idle);
    assign o_err_sync   = w_err;

`ifdef FFT_FRAME_CTRL_STATS_EN
    logic [31:0] r_latency, r_frames;
    logic        r_lat_wait, r_lat_on;

    // latency window: first accepted sample after CLR up to the first sync
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_latency  <= '0;
            r_frames   <= '0;
            r_lat_wait <= 1'b0;
            r_lat_on   <= 1'b0;
        end else begin
            if (w_last_hs) r_frames <= r_frames + 32'd1;
            if (r_state == c_clr) begin
                r_lat_wait <= 1'b1;
                r_lat_on   <= 1'b0;
            end else if (r_lat_wait && w_accept) begin
                r_lat_wait <= 1'b0;
                r_lat_on   <= 1'b1;
                r_latency  <= 32'd1;
            end else if (r_lat_on) begin
                if (r_fresh && i_fft_sync) r_lat_on  <= 1'b0;
                else if (w_ce)             r_latency <= r_latency + 32'd1;
            end
        end
    end

    assign o_latency = r_latency;
    assign o_frames  = r_frames;
`else
    assign o_latency = '0;
    assign o_frames  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_ctrl
// Brief    : Directed bench for fft_frame_ctrl with an identity-delay FFT core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_ctrl;
    localparam int IWIDTH = 8;
    localparam int OWIDTH = 10;
    localparam int LGN    = 3;
    localparam int PW     = 4;
    localparam int N      = 8;
    localparam int D      = N;

    logic clk = 1'b0;
    logic i_reset, i_flush, s_valid, s_ready, o_fft_reset, o_fft_ce, i_fft_sync;
    logic m_valid, m_ready, m_first, m_last, o_busy, o_err_sync;
    logic [2*IWIDTH-1:0] s_sample, o_fft_sample;
    logic [2*OWIDTH-1:0] i_fft_result, m_data;
    logic [LGN-1:0]      m_bin;
    logic [31:0]         o_latency, o_frames;

    int n_vec = 0;
    int n_err = 0;
    int bp_viol = 0;
    logic [24:0] q[$];

    always #5 clk = ~clk;

    fft_frame_ctrl #(.IWIDTH(IWIDTH), .OWIDTH(OWIDTH), .LGN(LGN), .PW(PW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_sample(s_sample),
        .o_fft_reset(o_fft_reset), .o_fft_ce(o_fft_ce), .o_fft_sample(o_fft_sample),
        .i_fft_result(i_fft_result), .i_fft_sync(i_fft_sync),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_bin(m_bin),
        .m_first(m_first), .m_last(m_last), .o_busy(o_busy), .o_err_sync(o_err_sync),
        .o_latency(o_latency), .o_frames(o_frames)
    );

    // Core model: output after ce k is the sample of ce k-D; sync marks each frame start
    int          core_cnt;
    logic [15:0] hist [0:1023];
    logic [15:0] core_smp;
    logic        force_sync;

    always @(posedge clk) begin
        if (o_fft_reset) core_cnt <= 0;
        else if (o_fft_ce) begin
            hist[core_cnt + 1] <= o_fft_sample;
            core_cnt           <= core_cnt + 1;
        end
    end

    always_comb begin
        core_smp   = (core_cnt > D) ? hist[core_cnt - D] : 16'h0;
        i_fft_sync = force_sync | ((core_cnt > D) && (((core_cnt - D - 1) % N) == 0));
        i_fft_result = {2'b00, core_smp[15:8], 2'b00, core_smp[7:0]};
    end

    function automatic logic [15:0] smp(input int v);
        return {8'(v), 8'(v ^ 'h5A)};
    endfunction

    function automatic logic [24:0] exp_rec(input int i, input int base);
        logic [15:0] s;
        s = smp(base + i);
        return {3'(i % N), (i % N) == 0, (i % N) == N - 1, 2'b00, s[15:8], 2'b00, s[7:0]};
    endfunction

    task automatic cyc(input bit sv, input logic [15:0] sd, input bit mr, input bit fl, output bit acc);
        @(negedge clk);
        s_valid = sv; s_sample = sd; m_ready = mr; i_flush = fl;
        #1;
        acc = s_valid & s_ready;
        if (m_valid && !m_ready && s_ready) bp_viol++;
        if (m_valid && m_ready) q.push_back({m_bin, m_first, m_last, m_data});
    endtask

    task automatic run_frames(input int nsamp, input int base, input bit gaps, input bit rdy_rand,
                              input int fl_mid, output bit timed_out);
        logic [15:0] gp, rp;
        int k, n;
        bit acc, pulsed, mr;
        gp = 16'b1101_1011_0111_1110;
        rp = 16'b1011_0010_1101_0100;
        k = 0; n = 0; pulsed = 0;
        q.delete(); bp_viol = 0;
        while (k < nsamp && n < 500) begin
            mr = rdy_rand ? rp[n % 16] : 1'b1;
            cyc(gaps ? gp[n % 16] : 1'b1, smp(base + k), mr, (k == fl_mid) && !pulsed, acc);
            if (k == fl_mid) pulsed = 1;
            if (acc) k++;
            n++;
        end
        while (o_busy && n < 1000) begin
            mr = rdy_rand ? rp[n % 16] : 1'b1;
            cyc(1'b0, 16'h0, mr, fl_mid < 0, acc);
            n++;
        end
        timed_out = (k < nsamp) || o_busy;
        cyc(1'b0, 16'h0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_reset();
        @(negedge clk);
        i_reset = 1; s_valid = 1; m_ready = 1;
        @(negedge clk); #1;
        n_vec++; if (o_fft_reset !== 1'b1) begin n_err++; $display("FAIL rst_fft_reset got %b want 1", o_fft_reset); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", o_busy); end
        n_vec++; if ({s_ready, o_fft_ce, m_valid} !== 3'b000) begin n_err++; $display("FAIL rst_handshake got %b want 000", {s_ready, o_fft_ce, m_valid}); end
        n_vec++; if ({m_bin, o_err_sync} !== 4'd0) begin n_err++; $display("FAIL rst_bin_err got %h want 0", {m_bin, o_err_sync}); end
        n_vec++; if ({o_latency, o_frames} !== 64'd0) begin n_err++; $display("FAIL rst_stats got %h want 0", {o_latency, o_frames}); end
        @(negedge clk);
        i_reset = 0; s_valid = 0;
        @(negedge clk); #1;
        n_vec++; if ({o_fft_reset, o_busy} !== 2'b00) begin n_err++; $display("FAIL idle_after_reset got %b want 00", {o_fft_reset, o_busy}); end
    endtask

    task automatic test_single_frame();
        bit to;
        run_frames(N, 1, 1'b0, 1'b0, -1, to);
        n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL single_timeout got %b want 0", to); end
        n_vec++; if (q.size() !== N) begin n_err++; $display("FAIL single_count got %0d want %0d", q.size(), N); end
        foreach (q[i]) begin
            n_vec++; if (q[i] !== exp_rec(i, 1)) begin n_err++; $display("FAIL single_rec%0d got %h want %h", i, q[i], exp_rec(i, 1)); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        run_frames(N, 30, 1'b0, 1'b1, -1, to);
        n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL bp_timeout got %b want 0", to); end
        n_vec++; if (q.size() !== N) begin n_err++; $display("FAIL bp_count got %0d want %0d", q.size(), N); end
        n_vec++; if (bp_viol !== 0) begin n_err++; $display("FAIL bp_sready_while_stalled got %0d want 0", bp_viol); end
        foreach (q[i]) begin
            n_vec++; if (q[i] !== exp_rec(i, 30)) begin n_err++; $display("FAIL bp_rec%0d got %h want %h", i, q[i], exp_rec(i, 30)); end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        run_frames(2 * N, 10, 1'b1, 1'b0, -1, to);
        n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL b2b_timeout got %b want 0", to); end
        n_vec++; if (q.size() !== 2 * N) begin n_err++; $display("FAIL b2b_count got %0d want %0d", q.size(), 2 * N); end
        foreach (q[i]) begin
            n_vec++; if (q[i] !== exp_rec(i, 10)) begin n_err++; $display("FAIL b2b_rec%0d got %h want %h", i, q[i], exp_rec(i, 10)); end
        end
    endtask

    task automatic test_flush_mid();
        bit to;
        run_frames(N, 50, 1'b0, 1'b0, 3, to);
        n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL flushmid_timeout got %b want 0", to); end
        n_vec++; if (q.size() !== N) begin n_err++; $display("FAIL flushmid_count got %0d want %0d", q.size(), N); end
        foreach (q[i]) begin
            n_vec++; if (q[i] !== exp_rec(i, 50)) begin n_err++; $display("FAIL flushmid_rec%0d got %h want %h", i, q[i], exp_rec(i, 50)); end
        end
    endtask

    task automatic test_reset_midframe();
        bit acc, to;
        int k;
        k = 0;
        for (int n = 0; n < 20 && k < 5; n++) begin
            cyc(1'b1, smp(200 + k), 1'b1, 1'b0, acc);
            if (acc) k++;
        end
        @(negedge clk);
        i_reset = 1; #1;
        n_vec++; if ({o_fft_reset, s_ready, o_fft_ce, m_valid, o_busy} !== 5'b10000) begin n_err++; $display("FAIL midrst_outputs got %b want 10000", {o_fft_reset, s_ready, o_fft_ce, m_valid, o_busy}); end
        @(negedge clk);
        i_reset = 0; s_valid = 0; #1;
        n_vec++; if ({o_fft_reset, o_busy, m_bin} !== 5'b0) begin n_err++; $display("FAIL midrst_after got %b want 0", {o_fft_reset, o_busy, m_bin}); end
        run_frames(N, 100, 1'b0, 1'b0, -1, to);
        n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL midrst_timeout got %b want 0", to); end
        n_vec++; if (q.size() !== N) begin n_err++; $display("FAIL midrst_count got %0d want %0d", q.size(), N); end
        foreach (q[i]) begin
            n_vec++; if (q[i] !== exp_rec(i, 100)) begin n_err++; $display("FAIL midrst_rec%0d got %h want %h", i, q[i], exp_rec(i, 100)); end
        end
    endtask

    task automatic test_err_sync();
        bit acc, found;
        int k;
        k = 0; found = 0;
        for (int n = 0; n < 20 && k < N; n++) begin
            cyc(1'b1, smp(60 + k), 1'b1, 1'b0, acc);
            if (acc) k++;
        end
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk); #1;
            if (m_valid && m_bin == 3'd7) found = 1;
            else begin s_valid = 0; m_ready = 1; i_flush = 1; end
        end
        n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL err_reach_bin7 got %b want 1", found); end
        m_ready = 0; force_sync = 1; #1;
        n_vec++; if (o_err_sync !== 1'b1) begin n_err++; $display("FAIL err_pulse got %b want 1", o_err_sync); end
        @(negedge clk);
        force_sync = 0; #1;
        n_vec++; if (o_err_sync !== 1'b0) begin n_err++; $display("FAIL err_single_cycle got %b want 0", o_err_sync); end
        n_vec++; if ({m_valid, m_bin, m_first} !== 5'b1_000_1) begin n_err++; $display("FAIL err_realign got %b want 10001", {m_valid, m_bin, m_first}); end
        @(negedge clk);
        i_reset = 1; i_flush = 0;
        @(negedge clk);
        i_reset = 0;
    endtask

    initial begin
        i_reset = 1; i_flush = 0; s_valid = 0; m_ready = 0; s_sample = '0; force_sync = 0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_flush_mid();
        test_reset_midframe();
        test_err_sync();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
